// File: rtl/sd_cmd_serial_host.sv
// rtl/sd_cmd_serial_host.sv - SD command-line engine: CRC7-framed 48-bit command out, optional 48-bit response in
//
// Ports:
//   i_clk, i_rst_n        system clock, synchronous active-low reset
//   i_sd_clk              divided SD clock, synchronous to i_clk
//   i_cmd_start           1-cycle request, accepted only while o_busy=0
//   i_cmd_index/arg       command index / argument, sampled on accept
//   i_rsp_en              expect a 48-bit short response, sampled on accept
//   i_cmd_i               CMD pad input
//   o_cmd_o, o_cmd_oe     CMD pad output value / output enable
//   o_busy, o_done        transaction in progress / 1-cycle completion pulse
//   o_rsp_index/arg       captured response bits [45:40] / [39:8]
//   o_timeout             no response start bit within RSP_TIMEOUT SD_CLK rises
//   o_crc_err             response CRC7 or end-bit error
//
// Optional feature: define SD_CMD_RSP_CRC_CHECK_EN to build the receive CRC7
// checker; without it o_crc_err is constant 0.
module sd_cmd_serial_host #(
    parameter int RSP_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sd_clk,
    input  logic        i_cmd_start,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_rsp_en,
    input  logic        i_cmd_i,
    output logic        o_cmd_o,
    output logic        o_cmd_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic [5:0]  o_rsp_index,
    output logic [31:0] o_rsp_arg,
    output logic        o_timeout,
    output logic        o_crc_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TX       = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_RX       = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RSP_TIMEOUT - 1);

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
        logic fb;
        fb = d ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t         r_state,     w_state_nxt;
    logic           r_sclk_q;
    logic [39:0]    r_frame,     w_frame_nxt;
    logic           r_rsp_en,    w_rsp_en_nxt;
    logic [5:0]     r_bit_cnt,   w_bit_cnt_nxt;
    logic [6:0]     r_crc,       w_crc_nxt;
    logic [TO_W-1:0] r_to_cnt,   w_to_cnt_nxt;
    logic [46:0]    r_rsp_sr,    w_rsp_sr_nxt;
    logic           r_cmd_o,     w_cmd_o_nxt;
    logic           r_cmd_oe,    w_cmd_oe_nxt;
    logic           r_done,      w_done_nxt;
    logic [5:0]     r_rsp_index, w_rsp_index_nxt;
    logic [31:0]    r_rsp_arg,   w_rsp_arg_nxt;
    logic           r_timeout,   w_timeout_nxt;
    logic           r_crc_err,   w_crc_err_nxt;

    logic           w_rise;
    logic           w_fall;
    logic [47:0]    w_rx_full;
    logic           w_unused;

    assign w_rise = i_sd_clk & ~r_sclk_q;
    assign w_fall = ~i_sd_clk & r_sclk_q;

    // Complete response as it stands once the current CMD bit is shifted in;
    // the start bit is not stored, so bit 47 is never meaningful here.
    assign w_rx_full = {r_rsp_sr, i_cmd_i};

`ifdef SD_CMD_RSP_CRC_CHECK_EN
    assign w_unused = w_rx_full[47];
`else
    assign w_unused = ^{w_rx_full[47], w_rx_full[7:1]};
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame;
        w_rsp_en_nxt    = r_rsp_en;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_crc_nxt       = r_crc;
        w_to_cnt_nxt    = r_to_cnt;
        w_rsp_sr_nxt    = r_rsp_sr;
        w_cmd_o_nxt     = r_cmd_o;
        w_cmd_oe_nxt    = r_cmd_oe;
        w_done_nxt      = 1'b0;
        w_rsp_index_nxt = r_rsp_index;
        w_rsp_arg_nxt   = r_rsp_arg;
        w_timeout_nxt   = r_timeout;
        w_crc_err_nxt   = r_crc_err;

        case (r_state)
            S_IDLE: begin
                if (i_cmd_start) begin
                    w_frame_nxt     = {1'b0, 1'b1, i_cmd_index, i_cmd_arg};
                    w_rsp_en_nxt    = i_rsp_en;
                    w_bit_cnt_nxt   = 6'd0;
                    w_crc_nxt       = 7'd0;
                    w_to_cnt_nxt    = '0;
                    w_rsp_index_nxt = 6'd0;
                    w_rsp_arg_nxt   = 32'd0;
                    w_timeout_nxt   = 1'b0;
                    w_crc_err_nxt   = 1'b0;
                    w_state_nxt     = S_TX;
                end
            end

            S_TX: begin
                if (w_fall) begin
                    if (r_bit_cnt < 6'd40) begin
                        w_cmd_o_nxt   = r_frame[39];
                        w_cmd_oe_nxt  = 1'b1;
                        w_crc_nxt     = crc7_step(r_crc, r_frame[39]);
                        w_frame_nxt   = {r_frame[38:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end else if (r_bit_cnt < 6'd47) begin
                        // CRC register is shifted out MSB-first and left at zero.
                        w_cmd_o_nxt   = r_crc[6];
                        w_crc_nxt     = {r_crc[5:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end else if (r_bit_cnt == 6'd47) begin
                        w_cmd_o_nxt   = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end else begin
                        // End bit has had its full SD_CLK low+high period.
                        w_cmd_o_nxt  = 1'b1;
                        w_cmd_oe_nxt = 1'b0;
                        if (r_rsp_en) begin
                            w_to_cnt_nxt = '0;
                            w_state_nxt  = S_WAIT_RSP;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_WAIT_RSP: begin
                if (w_rise) begin
                    if (!i_cmd_i) begin
                        w_bit_cnt_nxt = 6'd1;
                        w_crc_nxt     = 7'd0;
                        w_state_nxt   = S_RX;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_timeout_nxt = 1'b1;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end

            S_RX: begin
                if (w_rise) begin
                    w_rsp_sr_nxt = w_rx_full[46:0];
`ifdef SD_CMD_RSP_CRC_CHECK_EN
                    // Counts 1..39 carry response bits 46..8; the start bit
                    // (0) would leave a zero-initialised CRC unchanged.
                    if (r_bit_cnt <= 6'd39) begin
                        w_crc_nxt = crc7_step(r_crc, i_cmd_i);
                    end
`endif
                    if (r_bit_cnt == 6'd47) begin
                        w_rsp_index_nxt = w_rx_full[45:40];
                        w_rsp_arg_nxt   = w_rx_full[39:8];
`ifdef SD_CMD_RSP_CRC_CHECK_EN
                        w_crc_err_nxt   = (w_rx_full[7:1] != r_crc) | ~w_rx_full[0];
`endif
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sclk_q    <= 1'b0;
            r_frame     <= 40'd0;
            r_rsp_en    <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_crc       <= 7'd0;
            r_to_cnt    <= '0;
            r_rsp_sr    <= 47'd0;
            r_cmd_o     <= 1'b1;
            r_cmd_oe    <= 1'b0;
            r_done      <= 1'b0;
            r_rsp_index <= 6'd0;
            r_rsp_arg   <= 32'd0;
            r_timeout   <= 1'b0;
            r_crc_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sclk_q    <= i_sd_clk;
            r_frame     <= w_frame_nxt;
            r_rsp_en    <= w_rsp_en_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_crc       <= w_crc_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_rsp_sr    <= w_rsp_sr_nxt;
            r_cmd_o     <= w_cmd_o_nxt;
            r_cmd_oe    <= w_cmd_oe_nxt;
            r_done      <= w_done_nxt;
            r_rsp_index <= w_rsp_index_nxt;
            r_rsp_arg   <= w_rsp_arg_nxt;
            r_timeout   <= w_timeout_nxt;
            r_crc_err   <= w_crc_err_nxt;
        end
    end

    assign o_cmd_o     = r_cmd_o;
    assign o_cmd_oe    = r_cmd_oe;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_rsp_index = r_rsp_index;
    assign o_rsp_arg   = r_rsp_arg;
    assign o_timeout   = r_timeout;
`ifdef SD_CMD_RSP_CRC_CHECK_EN
    assign o_crc_err   = r_crc_err;
`else
    assign o_crc_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb/tb_sd_cmd_serial_host.sv - directed table-driven bench for sd_cmd_serial_host
module tb_sd_cmd_serial_host;

`ifdef SD_CMD_RSP_CRC_CHECK_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sd_clk;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        rsp_en;
    logic        cmd_i;
    logic        cmd_o;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    logic [5:0]  rsp_index;
    logic [31:0] rsp_arg;
    logic        timeout;
    logic        crc_err;

    sd_cmd_serial_host #(.RSP_TIMEOUT(64), .TO_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sd_clk    (sd_clk),
        .i_cmd_start (cmd_start),
        .i_cmd_index (cmd_index),
        .i_cmd_arg   (cmd_arg),
        .i_rsp_en    (rsp_en),
        .i_cmd_i     (cmd_i),
        .o_cmd_o     (cmd_o),
        .o_cmd_oe    (cmd_oe),
        .o_busy      (busy),
        .o_done      (done),
        .o_rsp_index (rsp_index),
        .o_rsp_arg   (rsp_arg),
        .o_timeout   (timeout),
        .o_crc_err   (crc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ren;
        logic        cen;
        int          cdly;
        logic [47:0] cbits;
        logic [47:0] frame;
        logic [5:0]  eidx;
        logic [31:0] earg;
        logic        eto;
        logic        ecrc;
        int          erises;
    } vec_t;

    localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD17 = 48'h51_0000_0000_55;
    localparam logic [47:0] F_CMD55 = 48'h77_0000_0000_65;
    localparam logic [47:0] R_CMD8  = 48'h08_0000_01AA_13;
    localparam logic [47:0] R_BAD   = 48'h08_0000_11AA_13;

    vec_t vecs [6];

    int checks;
    int failures;
    int ccnt;
    int tcnt;
    logic prev_sd;
    logic fall_now;
    logic rise_now;
    logic prev_oe;
    logic [47:0] tx_frame;
    int   tx_n;
    int   first_lat;
    int   done_cnt;
    logic oe_low;
    int   rises_after;
    int   rises_at_done;
    logic card_en;
    int   card_dly;
    logic [47:0] card_bits;
    int   card_phase;
    int   card_wait;
    int   card_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One CLK cycle: drive at negedge (SD_CLK period 4 CLK, card model), sample #1 after posedge.
    task automatic tick();
        @(negedge clk);
        ccnt++;
        prev_sd  = sd_clk;
        sd_clk   = ((ccnt / 2) % 2) == 1;
        fall_now = prev_sd & ~sd_clk;
        rise_now = ~prev_sd & sd_clk;
        if (fall_now) begin
            if (card_phase == 2) begin
                card_n++;
                if (card_n >= 48) begin
                    cmd_i = 1'b1;
                    card_phase = 0;
                end else begin
                    cmd_i = card_bits[47 - card_n];
                end
            end else if (card_phase == 1) begin
                card_wait--;
                if (card_wait == 0) begin
                    card_phase = 2;
                    card_n = 0;
                    cmd_i = card_bits[47];
                end
            end
        end
        @(posedge clk);
        #1;
        tcnt++;
        if (fall_now && cmd_oe) begin
            tx_frame = {tx_frame[46:0], cmd_o};
            if (tx_n == 0) first_lat = tcnt;
            tx_n++;
        end
        if (prev_oe && !cmd_oe) begin
            oe_low = 1'b1;
            if (card_en) begin
                card_phase = 1;
                card_wait  = card_dly;
            end
        end
        if (rise_now && oe_low) rises_after++;
        prev_oe = cmd_oe;
        if (done) begin
            done_cnt++;
            rises_at_done = rises_after;
        end
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                             input logic cen, input int cdly, input logic [47:0] cbits);
        tx_frame = 48'd0; tx_n = 0; first_lat = 0; done_cnt = 0; tcnt = 0;
        oe_low = 1'b0; rises_after = 0; rises_at_done = -1;
        card_en = cen; card_dly = cdly; card_bits = cbits; card_phase = 0; cmd_i = 1'b1;
        cmd_start = 1'b1; cmd_index = idx; cmd_arg = arg; rsp_en = ren;
        tick();
        cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; rsp_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 1500) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        vecs[0] = '{6'd0,  32'h0,     1'b0, 1'b0, 0,  48'h0,  F_CMD0,  6'd0, 32'h0,     1'b0, 1'b0,   -1};
        vecs[1] = '{6'd8,  32'h1AA,   1'b1, 1'b1, 1,  R_CMD8, F_CMD8,  6'd8, 32'h1AA,   1'b0, 1'b0,   -1};
        vecs[2] = '{6'd8,  32'h1AA,   1'b1, 1'b1, 1,  R_BAD,  F_CMD8,  6'd8, 32'h11AA,  1'b0, CRC_EN, -1};
        vecs[3] = '{6'd17, 32'h0,     1'b1, 1'b0, 0,  48'h0,  F_CMD17, 6'd0, 32'h0,     1'b1, 1'b0,   64};
        vecs[4] = '{6'd8,  32'h1AA,   1'b1, 1'b1, 63, R_CMD8, F_CMD8,  6'd8, 32'h1AA,   1'b0, 1'b0,   -1};
        vecs[5] = '{6'd55, 32'h0,     1'b1, 1'b1, 64, R_CMD8, F_CMD55, 6'd0, 32'h0,     1'b1, 1'b0,   64};

        checks = 0; failures = 0; ccnt = 0; tcnt = 0;
        rst_n = 1'b0; sd_clk = 1'b0; cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
        rsp_en = 1'b0; cmd_i = 1'b1; prev_oe = 1'b0;
        tx_frame = 48'd0; tx_n = 0; first_lat = 0; done_cnt = 0; oe_low = 1'b0;
        rises_after = 0; rises_at_done = -1; card_en = 1'b0; card_dly = 0; card_bits = 48'd0;
        card_phase = 0; card_wait = 0; card_n = 0;

        repeat (4) tick();
        chk("rst_cmd_o", 64'(cmd_o), 64'd1);
        chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_rsp", 64'({rsp_index, rsp_arg}), 64'd0);
        chk("rst_flags", 64'({timeout, crc_err}), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 6; i++) begin
            start_cmd(vecs[i].idx, vecs[i].arg, vecs[i].ren, vecs[i].cen, vecs[i].cdly, vecs[i].cbits);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_done($sformatf("v%0d", i));
            chk($sformatf("v%0d_frame", i), 64'(tx_frame), 64'(vecs[i].frame));
            chk($sformatf("v%0d_nbits", i), 64'(tx_n), 64'd48);
            chk($sformatf("v%0d_latency_ok", i), 64'((first_lat - 1) >= 1 && (first_lat - 1) <= 4), 64'd1);
            chk($sformatf("v%0d_rsp_index", i), 64'(rsp_index), 64'(vecs[i].eidx));
            chk($sformatf("v%0d_rsp_arg", i), 64'(rsp_arg), 64'(vecs[i].earg));
            chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'(vecs[i].eto));
            chk($sformatf("v%0d_crc_err", i), 64'(crc_err), 64'(vecs[i].ecrc));
            if (vecs[i].erises >= 0)
                chk($sformatf("v%0d_rises_to_done", i), 64'(rises_at_done), 64'(vecs[i].erises));
            tick();
            chk($sformatf("v%0d_done_once", i), 64'(done_cnt), 64'd1);
            chk($sformatf("v%0d_idle", i), 64'({busy, cmd_oe, cmd_o}), 64'b001);
        end

        // Reset while bit 20 of a command is on the line.
        begin
            int n;
            start_cmd(6'd8, 32'h1AA, 1'b1, 1'b0, 0, 48'h0);
            n = 0;
            while (tx_n < 21 && n < 400) begin
                tick();
                n++;
            end
            chk("rst_mid_reached_bit20", 64'(tx_n), 64'd21);
            rst_n = 1'b0;
            tick();
            chk("rst_mid_lines", 64'({cmd_oe, cmd_o}), 64'b01);
            chk("rst_mid_busy_done", 64'({busy, done}), 64'd0);
            rst_n = 1'b1;
            repeat (20) tick();
            chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
            start_cmd(6'd0, 32'h0, 1'b0, 1'b0, 0, 48'h0);
            wait_done("rst_mid_cmd0");
            chk("rst_mid_cmd0_frame", 64'(tx_frame), 64'(F_CMD0));
            tick();
        end

        // Request while busy is ignored; request in the DONE cycle is taken.
        begin
            start_cmd(6'd0, 32'h0, 1'b0, 1'b0, 0, 48'h0);
            repeat (10) tick();
            cmd_start = 1'b1; cmd_index = 6'd5; cmd_arg = 32'hFFFF_FFFF; rsp_en = 1'b1;
            tick();
            cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; rsp_en = 1'b0;
            wait_done("busy_poke");
            chk("busy_poke_frame", 64'(tx_frame), 64'(F_CMD0));
            chk("busy_poke_nbits", 64'(tx_n), 64'd48);
            chk("busy_poke_flags", 64'({timeout, crc_err}), 64'd0);
            start_cmd(6'd55, 32'h0, 1'b0, 1'b0, 0, 48'h0);
            chk("done_cycle_accept_busy", 64'(busy), 64'd1);
            wait_done("chained");
            chk("chained_frame", 64'(tx_frame), 64'(F_CMD55));
            tick();
            chk("chained_done_once", 64'(done_cnt), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
